// File: rtl/sample_accumulator_if.sv
// Sample-in / result-out handshake bundle for sample_accumulator.
// The master side feeds samples and drains results; the slave side is the accumulator.
interface sample_accumulator_if #(
  parameter int BIT_WIDTH = 16,
  parameter int CNT_W     = 3
);
  logic [BIT_WIDTH-1:0] data_in;
  logic                 data_valid;
  logic                 data_ready;
  logic                 result_ready;
  logic                 result_valid;
  logic [BIT_WIDTH-1:0] sum_out;
  logic                 overflow_flag;
  logic [CNT_W-1:0]     sample_count;

  modport master (
    output data_in, data_valid, result_ready,
    input  data_ready, result_valid, sum_out, overflow_flag, sample_count
  );

  modport slave (
    input  data_in, data_valid, result_ready,
    output data_ready, result_valid, sum_out, overflow_flag, sample_count
  );
endinterface

// File: rtl/sample_accumulator.sv
// Batch accumulator around a ripple-carry adder: NUM_SAMPLES samples (one per 2 clocks max)
// are summed modulo 2^BIT_WIDTH with a sticky carry flag; the result is held until result_ready.
module adder_nbit #(
  parameter int BIT_WIDTH = 16
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 overflow
);
  always_comb begin : ripple
    logic c;
    c   = carry_in;
    sum = '0;
    for (int i = 0; i < BIT_WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    overflow = c;
  end
endmodule

module sample_accumulator #(
  parameter int BIT_WIDTH   = 16,
  parameter int NUM_SAMPLES = 4,
  parameter int CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  sample_accumulator_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [BIT_WIDTH-1:0] acc_q, acc_d;
  logic [BIT_WIDTH-1:0] operand_q, operand_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 data_ready_q, result_valid_q;

  logic [BIT_WIDTH-1:0] add_sum;
  logic                 add_ovf;
  logic [CNT_W-1:0]     count_inc;

  adder_nbit #(.BIT_WIDTH(BIT_WIDTH)) u_adder (
    .a        (acc_q),
    .b        (operand_q),
    .carry_in (1'b0),
    .sum      (add_sum),
    .overflow (add_ovf)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    operand_d = operand_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    count_inc = count_q + CNT_W'(1);
    // clear wins over every state, including a pending result handshake
    if (clear) begin
      state_d   = S_IDLE;
      acc_d     = '0;
      operand_d = '0;
      count_d   = '0;
      ovf_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.data_valid) begin
            operand_d = bus.data_in;
            state_d   = S_ADD;
          end
        end
        S_ADD: begin
          acc_d   = add_sum;
          ovf_d   = ovf_q | add_ovf;
          count_d = count_inc;
          state_d = (count_inc == CNT_W'(NUM_SAMPLES)) ? S_DONE : S_IDLE;
        end
        S_DONE: begin
          if (bus.result_ready) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Handshake outputs are decoded from the next state so they leave a flop
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= S_IDLE;
      acc_q          <= '0;
      operand_q      <= '0;
      count_q        <= '0;
      ovf_q          <= 1'b0;
      data_ready_q   <= 1'b1;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      operand_q      <= operand_d;
      count_q        <= count_d;
      ovf_q          <= ovf_d;
      data_ready_q   <= (state_d == S_IDLE);
      result_valid_q <= (state_d == S_DONE);
    end
  end

  assign bus.data_ready    = data_ready_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.sum_out       = acc_q;
  assign bus.overflow_flag = ovf_q;
  assign bus.sample_count  = count_q;
endmodule

// File: tb/tb_sample_accumulator.sv
// Bench for sample_accumulator: directed batches plus random traffic against a
// transaction-level model holding the list of samples added in the current batch.
module tb_sample_accumulator;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic clk = 1'b0;
  logic n_rst;
  logic clear;

  always #5 clk = ~clk;

  sample_accumulator_if #(.BIT_WIDTH(W), .CNT_W(CW)) bus ();

  sample_accumulator #(.BIT_WIDTH(W), .NUM_SAMPLES(N)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Model: samples already added this batch, plus one sample in flight
  bit          m_busy;
  bit          m_done;
  int unsigned m_pend;
  int unsigned m_q[$];

  function automatic int unsigned exp_sum();
    int unsigned t = 0;
    foreach (m_q[i]) t = (t + m_q[i]) % (1 << W);
    return t;
  endfunction

  function automatic bit exp_ovf();
    int unsigned t = 0;
    bit o = 0;
    foreach (m_q[i]) begin
      t = t + m_q[i];
      if (t >= (1 << W)) begin
        o = 1;
        t = t - (1 << W);
      end
    end
    return o;
  endfunction

  function automatic bit exp_ready();
    return !m_busy && !m_done;
  endfunction

  task automatic model_reset();
    m_busy = 0;
    m_done = 0;
    m_pend = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit c, input bit dv, input int unsigned d, input bit rr);
    if (c) begin
      model_reset();
    end else if (m_done) begin
      if (rr) begin
        m_q.delete();
        m_done = 0;
      end
    end else if (m_busy) begin
      m_q.push_back(m_pend);
      m_busy = 0;
      if (m_q.size() == N) m_done = 1;
    end else if (dv) begin
      m_pend = d;
      m_busy = 1;
    end
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, "_ready"}, 32'(bus.data_ready), 32'(exp_ready()));
    chk({ph, "_valid"}, 32'(bus.result_valid), 32'(m_done));
    chk({ph, "_sum"}, 32'(bus.sum_out), exp_sum());
    chk({ph, "_ovf"}, 32'(bus.overflow_flag), 32'(exp_ovf()));
    chk({ph, "_cnt"}, 32'(bus.sample_count), m_q.size());
  endtask

  // Called at a falling edge; applies inputs, checks, crosses one rising edge
  task automatic cyc(input bit c, input bit dv, input logic [W-1:0] d, input bit rr, input string ph);
    clear            = c;
    bus.data_valid   = dv;
    bus.data_in      = d;
    bus.result_ready = rr;
    check_outputs(ph);
    @(posedge clk);
    model_step(c, dv, int'(d), rr);
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] d, input string ph);
    bit taken = 0;
    for (int i = 0; i < 20 && !taken; i++) begin
      taken = exp_ready();
      cyc(0, 1, d, 0, ph);
    end
    chk({ph, "_accept"}, 32'(taken), 32'd1);
  endtask

  initial begin
    n_rst            = 1'b0;
    clear            = 1'b0;
    bus.data_valid   = 1'b0;
    bus.data_in      = '0;
    bus.result_ready = 1'b0;
    model_reset();
    #12;
    check_outputs("rst");
    @(negedge clk);
    n_rst = 1'b1;

    // Basic batch 1..4
    send(16'd1, "b1"); send(16'd2, "b2"); send(16'd3, "b3"); send(16'd4, "b4");
    chk("basic_rv_early", 32'(bus.result_valid), 32'd0);
    cyc(0, 0, 16'd0, 0, "b_add");
    chk("basic_rv", 32'(bus.result_valid), 32'd1);
    chk("basic_sum", 32'(bus.sum_out), 32'd10);
    chk("basic_cnt", 32'(bus.sample_count), 32'd4);
    cyc(0, 0, 16'd0, 1, "b_pop");

    // Carry sets the sticky flag and survives later additions
    send(16'hFFFF, "o1"); send(16'h0002, "o2"); send(16'h0000, "o3"); send(16'h0000, "o4");
    cyc(0, 0, 16'd0, 0, "o_add");
    chk("ovf_sum", 32'(bus.sum_out), 32'h0001);
    chk("ovf_flag", 32'(bus.overflow_flag), 32'd1);

    // Result held under backpressure while samples are offered
    for (int i = 0; i < 5; i++) cyc(0, 1, 16'h1234, 0, "bp");
    chk("bp_sum", 32'(bus.sum_out), 32'h0001);
    chk("bp_ready", 32'(bus.data_ready), 32'd0);
    cyc(0, 1, 16'h1234, 1, "bp_pop");
    chk("bp_after_sum", 32'(bus.sum_out), 32'd0);
    chk("bp_after_ready", 32'(bus.data_ready), 32'd1);
    cyc(0, 0, 16'd0, 0, "bp_idle");

    // Clear mid-batch drops partial work and the same-cycle sample
    send(16'd5, "c1"); send(16'd7, "c2");
    cyc(0, 0, 16'd0, 0, "c_add");
    chk("clr_cnt_before", 32'(bus.sample_count), 32'd2);
    cyc(1, 1, 16'd99, 0, "c_clr");
    chk("clr_sum", 32'(bus.sum_out), 32'd0);
    chk("clr_cnt", 32'(bus.sample_count), 32'd0);
    chk("clr_ready", 32'(bus.data_ready), 32'd1);
    send(16'd10, "c3"); send(16'd20, "c4"); send(16'd30, "c5"); send(16'd40, "c6");
    cyc(0, 0, 16'd0, 0, "c_add2");
    chk("clr_batch_sum", 32'(bus.sum_out), 32'd100);
    cyc(0, 0, 16'd0, 1, "c_pop");

    // Gapped 0x8000 samples
    for (int k = 0; k < 4; k++) begin
      send(16'h8000, "g");
      for (int j = 0; j < 3; j++) cyc(0, 0, 16'd0, 0, "g_gap");
    end
    chk("gap_sum", 32'(bus.sum_out), 32'h0000);
    chk("gap_ovf", 32'(bus.overflow_flag), 32'd1);
    chk("gap_cnt", 32'(bus.sample_count), 32'd4);
    chk("gap_rv", 32'(bus.result_valid), 32'd1);
    cyc(0, 0, 16'd0, 1, "g_pop");

    // Asynchronous reset between accept edge and add edge
    send(16'd9, "r1"); send(16'd3, "r2");
    chk("pre_rst_ready", 32'(bus.data_ready), 32'd0);
    #1 n_rst = 1'b0;
    #1;
    chk("arst_sum", 32'(bus.sum_out), 32'd0);
    chk("arst_cnt", 32'(bus.sample_count), 32'd0);
    chk("arst_ovf", 32'(bus.overflow_flag), 32'd0);
    chk("arst_rv", 32'(bus.result_valid), 32'd0);
    chk("arst_ready", 32'(bus.data_ready), 32'd1);
    model_reset();
    @(negedge clk);
    check_outputs("arst_hold");
    n_rst = 1'b1;
    send(16'd1, "p1"); send(16'd2, "p2"); send(16'd3, "p3"); send(16'd4, "p4");
    cyc(0, 0, 16'd0, 0, "p_add");
    chk("post_rst_sum", 32'(bus.sum_out), 32'd10);
    chk("post_rst_rv", 32'(bus.result_valid), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] d;
      case ($urandom_range(0, 3))
        0:       d = 16'hFFFF;
        1:       d = 16'h8000;
        default: d = W'($urandom);
      endcase
      cyc($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, d,
          $urandom_range(0, 2) == 0, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sample_accumulator.md
# sample_accumulator

Sequential accumulator that sits directly upstream of, and wraps, the `adder_nbit` ripple-carry adder. It accepts a stream of `BIT_WIDTH`-bit samples over a valid/ready handshake and drives each one, with the running total, into an internal `adder_nbit` instance. After `NUM_SAMPLES` additions it presents the total and a sticky overflow flag over a second valid/ready handshake. It is the first registered stage that exercises the adder in a clocked datapath.

## Interface
- `BIT_WIDTH`, default 16: sample, accumulator and adder width.
- `NUM_SAMPLES`, default 4: additions per batch; must be at least 1.
- `CNT_W`, derived as `$clog2(NUM_SAMPLES+1)`: width of `sample_count`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous batch abort.
- `data_in` in `BIT_WIDTH`: sample value.
- `data_valid` in 1: `data_in` is valid.
- `data_ready` out 1: block can accept a sample.
- `result_ready` in 1: consumer accepts the result.
- `result_valid` out 1: `sum_out` and `overflow_flag` hold a completed batch.
- `sum_out` out `BIT_WIDTH`: accumulator value.
- `overflow_flag` out 1: at least one addition in the batch produced a carry-out.
- `sample_count` out `CNT_W`: additions completed in the current batch.

## Operation
- Internal registers: `acc` (`BIT_WIDTH`), `operand` (`BIT_WIDTH`), `count` (`CNT_W`), `ovf` (1), and `state`.
- `sum_out` = `acc`, `sample_count` = `count`, `overflow_flag` = `ovf`.
- One `adder_nbit #(BIT_WIDTH)` instance: `a`=`acc`, `b`=`operand`, `carry_in`=0. Its `sum` and `overflow` are used only in the `ADD` state.
- FSM states: `IDLE`, `ADD`, `DONE`. Outputs are Moore decodes: `data_ready` = (state==`IDLE`); `result_valid` = (state==`DONE`).
- `IDLE`: if `data_valid`, then `operand` <= `data_in` and go to `ADD`; otherwise stay.
- `ADD`: `acc` <= adder `sum`; `ovf` <= `ovf` | adder `overflow`; `count` <= `count`+1. Go to `DONE` if `count`+1 == `NUM_SAMPLES`, else go to `IDLE`.
- `DONE`: all registers hold. `data_valid` is ignored. If `result_ready`, then `acc`, `count` and `ovf` <= 0 and go to `IDLE`.
- Arithmetic: sum is modulo 2^`BIT_WIDTH`. A carry-out never saturates `acc`; it only sets `ovf`.
- `clear`, when high, takes priority in every state:
  - `acc`, `count`, `ovf` and `operand` <= 0; state <= `IDLE`.
  - A sample presented in the same cycle is not accepted.
  - A pending `DONE` result is discarded.
  - `clear` together with `result_ready` in `DONE` gives the same end state as a normal handshake.
- Reset (`n_rst`=0), asynchronous and at any time, including mid-`ADD`:
  - state = `IDLE`; `acc`, `operand`, `count` and `ovf` = 0.
  - Outputs during and after reset: `data_ready`=1, `result_valid`=0, `sum_out`=0, `overflow_flag`=0, `sample_count`=0.

## Timing
- A sample is accepted on the rising edge where `data_ready`&`data_valid`=1 (edge E0).
- `acc`, `ovf` and `count` update at the next edge (E1). `data_ready` is low for exactly one cycle between E0 and E1.
- Maximum throughput is one sample per 2 clocks.
- `result_valid` goes high immediately after E1 of the final sample. Latency from the final accept edge to `result_valid` is 1 clock.
- `result_valid` stays high, with `sum_out` and `overflow_flag` stable, until the edge where `result_ready`=1. At that edge outputs return to 0 and `data_ready` returns to 1. The next sample can be accepted at the following edge.
- The adder path `acc`+`operand` must settle within one clock period. Registers `acc` and `operand` are stable for the whole `ADD` cycle.
- No combinational path from `data_valid`/`result_ready` to `data_ready`/`result_valid`.

## Test plan
- Reset: drive `n_rst`=0 mid-`ADD`, between E0 and E1 → immediately `sum_out`=0, `sample_count`=0, `overflow_flag`=0, `result_valid`=0, `data_ready`=1. After release, the next batch sums correctly.
- Basic batch (16-bit, `NUM_SAMPLES`=4): samples 1, 2, 3, 4 with `data_valid` held high → `sample_count` steps 1→4, `sum_out`=10, `overflow_flag`=0, `result_valid`=1 one clock after the 4th accept edge.
- Overflow: samples 0xFFFF, 0x0002, 0x0000, 0x0000 → `sum_out`=0x0001, `overflow_flag`=1, and the flag stays 1 through the later additions.
- Backpressure: hold `result_ready`=0 for 5 cycles in `DONE` while `data_valid`=1 → `result_valid` stays 1, `data_ready` stays 0, `sum_out` is unchanged, and no sample is consumed. Then `result_ready`=1 for one cycle → next cycle `sum_out`=0 and `data_ready`=1.
- Clear mid-batch: accept 5 and 7 (`sample_count`=2), then pulse `clear` together with `data_valid`=1 → `sum_out`=0, `sample_count`=0, and that sample is not taken. Samples 10, 20, 30, 40 then give `sum_out`=100.
- Gaps: samples 0x8000 ×4, with `data_valid` low 3 cycles between each → `sum_out`=0x0000, `overflow_flag`=1, and exactly 4 accepts are counted.
